uart_rx_sampler: RTL

Serial byte receiver that feeds the stopwatch command parser. It oversamples the asynchronous `rx_serial` line at the system clock, recovers 8N1 frames (LSB first), and presents each good byte with a single-cycle valid strobe. Framing errors, and parity errors when parity is compiled in, are flagged with their own strobes and never produce a valid strobe.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_sampler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// bit-period helper and the ASCII command codes used by the stopwatch parser.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_t;

  localparam logic [7:0] ASCII_S = 8'h53;
  localparam logic [7:0] ASCII_s = 8'h73;
  localparam logic [7:0] ASCII_0 = 8'h30;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; the reset value is a
// parameter so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// producing one-cycle valid / framing-error / parity-error strobes.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_dv,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic rxs;

  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_q, par_bad_d;
  logic            perr_q, perr_d;
`endif

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rx_serial),
    .q_o  (rxs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        // Mid-start-bit check rejects short glitches on an idle line.
        if (cnt_q == CntHalf) begin
          if (!rxs) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          par_bad_d = (rxs != ^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              byte_d = shift_q;
              dv_d   = 1'b1;
            end
`else
            byte_d = shift_q;
            dv_d   = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_byte      = byte_q;
  assign rx_dv        = dv_q;
  assign rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
